// File: rtl/imm_lut_loader_pkg.sv
// Shared constants and FSM state type for the immediate LUT loader.
package imm_lut_loader_pkg;
  localparam int LUT_SIZE = 32;
  localparam int IDX_W    = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } state_t;
endpackage

// File: rtl/imm_lut_ram.sv
// Immediate entry storage: one synchronous write port, one combinational read port,
// every entry cleared to zero by the asynchronous reset.
module imm_lut_ram
  import imm_lut_loader_pkg::*;
#(
  parameter int DW    = 8,
  parameter int DEPTH = LUT_SIZE
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_we,
  input  logic [IDX_W-1:0] i_waddr,
  input  logic [DW-1:0]    i_wdata,
  input  logic [IDX_W-1:0] i_raddr,
  output logic [DW-1:0]    o_rdata
);
  logic [DW-1:0] r_mem [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Read sees the pre-edge contents, so a same-cycle write shows up one cycle later.
  assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/imm_lut_loader.sv
// Loads a 32-entry immediate table from a valid/ready stream and serves
// zero-latency reads by index once the table is complete.
module imm_lut_loader
  import imm_lut_loader_pkg::*;
#(
  parameter int DATA_PATH_WIDTH = 8,
  parameter int LUT_SIZE        = imm_lut_loader_pkg::LUT_SIZE
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       load_start,
  input  logic                       load_valid,
  input  logic [DATA_PATH_WIDTH-1:0] load_data,
  output logic                       load_ready,
  input  logic [IDX_W-1:0]           index,
  output logic [DATA_PATH_WIDTH-1:0] imm_value,
  output logic                       imm_valid,
  output logic                       busy,
  output logic [5:0]                 load_count,
  output logic                       load_err
);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LUT_SIZE - 1);

  state_t           r_state;
  state_t           w_state_next;
  logic [IDX_W-1:0] r_ptr;
  logic [5:0]       r_load_count;
  logic             r_load_err;
  logic             w_load_ready;
  logic             w_busy;
  logic             w_imm_valid;
  logic             w_hs;
  logic             w_start_accept;
  logic             w_violation;

  assign w_hs           = load_valid && w_load_ready;
  assign w_start_accept = load_start && (r_state != ST_LOAD);
  assign w_violation    = (load_start && (r_state == ST_LOAD)) ||
                          (load_valid && (r_state != ST_LOAD));

  always_comb begin
    w_state_next = r_state;
    w_load_ready = 1'b0;
    w_busy       = 1'b0;
    w_imm_valid  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (load_start) w_state_next = ST_LOAD;
      end
      ST_LOAD: begin
        w_load_ready = 1'b1;
        w_busy       = 1'b1;
        if (w_hs && (r_ptr == LAST_IDX)) w_state_next = ST_DONE;
      end
      ST_DONE: begin
        w_imm_valid = 1'b1;
        if (load_start) w_state_next = ST_LOAD;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_ptr        <= '0;
      r_load_count <= '0;
      r_load_err   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_start_accept) begin
        r_ptr        <= '0;
        r_load_count <= '0;
      end else if (w_hs) begin
        // Pointer parks on the last entry instead of wrapping to 0.
        if (r_ptr != LAST_IDX) r_ptr <= r_ptr + 1'b1;
        r_load_count <= r_load_count + 6'd1;
      end
      // An accepted start wins over a violation seen in the same cycle.
      if (w_start_accept)   r_load_err <= 1'b0;
      else if (w_violation) r_load_err <= 1'b1;
    end
  end

  imm_lut_ram #(
    .DW    (DATA_PATH_WIDTH),
    .DEPTH (LUT_SIZE)
  ) u_ram (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_we    (w_hs),
    .i_waddr (r_ptr),
    .i_wdata (load_data),
    .i_raddr (index),
    .o_rdata (imm_value)
  );

  assign load_ready = w_load_ready;
  assign busy       = w_busy;
  assign imm_valid  = w_imm_valid;
  assign load_count = r_load_count;
  assign load_err   = r_load_err;
endmodule

// File: tb/tb_imm_lut_loader.sv
// Directed bench for imm_lut_loader: each task drives one scenario and checks inline.
module tb_imm_lut_loader;
  import imm_lut_loader_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       load_start = 1'b0;
  logic       load_valid = 1'b0;
  logic [7:0] load_data = '0;
  logic       load_ready;
  logic [4:0] index = '0;
  logic [7:0] imm_value;
  logic       imm_valid;
  logic       busy;
  logic [5:0] load_count;
  logic       load_err;

  int total = 0;
  int bad   = 0;
  logic [7:0] exp_mem [32];

  imm_lut_loader #(.DATA_PATH_WIDTH(8), .LUT_SIZE(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_start (load_start),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_ready (load_ready),
    .index      (index),
    .imm_value  (imm_value),
    .imm_valid  (imm_valid),
    .busy       (busy),
    .load_count (load_count),
    .load_err   (load_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    load_start = 1'b1;
    step();
    load_start = 1'b0;
  endtask

  task automatic push(input logic [7:0] d);
    load_valid = 1'b1;
    load_data  = d;
    step();
    load_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    total++; if (load_ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%0b exp=0", load_ready); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    total++; if (imm_valid !== 1'b0) begin bad++; $display("FAIL reset_imm_valid got=%0b exp=0", imm_valid); end
    total++; if (load_count !== 6'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", load_count); end
    total++; if (load_err !== 1'b0) begin bad++; $display("FAIL reset_err got=%0b exp=0", load_err); end
    total++; if (imm_value !== 8'h00) begin bad++; $display("FAIL reset_imm_value got=%02h exp=00", imm_value); end
    step();
    rst_n = 1'b1;
    step();
    $display("test_reset done");
  endtask

  task automatic test_full_load();
    pulse_start();
    total++; if (busy !== 1'b1 || load_ready !== 1'b1) begin bad++; $display("FAIL load_enter busy=%0b ready=%0b exp=1/1", busy, load_ready); end
    for (int i = 0; i < 32; i++) begin
      if (i == 5) begin
        index = 5'd5; #1;
        total++; if (imm_value !== 8'h00) begin bad++; $display("FAIL same_cycle_old got=%02h exp=00", imm_value); end
      end
      if (i == 31) begin
        total++; if (imm_valid !== 1'b0) begin bad++; $display("FAIL early_valid got=%0b exp=0", imm_valid); end
      end
      push(8'(i));
      if (i == 5) begin
        total++; if (imm_value !== 8'h05) begin bad++; $display("FAIL same_cycle_new got=%02h exp=05", imm_value); end
      end
    end
    total++; if (imm_valid !== 1'b1) begin bad++; $display("FAIL full_valid got=%0b exp=1", imm_valid); end
    total++; if (load_count !== 6'd32) begin bad++; $display("FAIL full_count got=%0d exp=32", load_count); end
    total++; if (busy !== 1'b0 || load_ready !== 1'b0) begin bad++; $display("FAIL full_done busy=%0b ready=%0b exp=0/0", busy, load_ready); end
    index = 5'd5; #1;
    total++; if (imm_value !== 8'h05) begin bad++; $display("FAIL full_idx5 got=%02h exp=05", imm_value); end
    index = 5'd31; #1;
    total++; if (imm_value !== 8'h1F) begin bad++; $display("FAIL full_idx31 got=%02h exp=1f", imm_value); end
    step();
    total++; if (imm_valid !== 1'b1) begin bad++; $display("FAIL full_hold got=%0b exp=1", imm_valid); end
    $display("test_full_load done count=%0d", load_count);
  endtask

  task automatic test_stall();
    pulse_start();
    for (int i = 0; i < 32; i++) exp_mem[i] = 8'(8'h40 + i);
    for (int i = 0; i < 8; i++) push(exp_mem[i]);
    for (int c = 0; c < 10; c++) begin
      step();
      total++; if (busy !== 1'b1 || load_count !== 6'd8) begin bad++; $display("FAIL stall_hold c=%0d busy=%0b count=%0d exp=1/8", c, busy, load_count); end
    end
    for (int i = 8; i < 32; i++) push(exp_mem[i]);
    total++; if (imm_valid !== 1'b1 || load_count !== 6'd32) begin bad++; $display("FAIL stall_done valid=%0b count=%0d exp=1/32", imm_valid, load_count); end
    for (int i = 0; i < 32; i++) begin
      index = 5'(i); #1;
      total++; if (imm_value !== exp_mem[i]) begin bad++; $display("FAIL stall_data idx=%0d got=%02h exp=%02h", i, imm_value, exp_mem[i]); end
    end
    $display("test_stall done");
  endtask

  task automatic test_start_during_load();
    pulse_start();
    total++; if (load_err !== 1'b0) begin bad++; $display("FAIL sdl_err_clear got=%0b exp=0", load_err); end
    for (int i = 0; i < 32; i++) exp_mem[i] = 8'(i) ^ 8'h5A;
    for (int i = 0; i < 32; i++) begin
      load_start = (i == 12);
      push(exp_mem[i]);
      load_start = 1'b0;
      if (i == 12) begin
        total++; if (load_err !== 1'b1 || load_count !== 6'd13) begin bad++; $display("FAIL sdl_err err=%0b count=%0d exp=1/13", load_err, load_count); end
      end
    end
    total++; if (imm_valid !== 1'b1 || load_count !== 6'd32) begin bad++; $display("FAIL sdl_done valid=%0b count=%0d exp=1/32", imm_valid, load_count); end
    for (int i = 0; i < 32; i++) begin
      index = 5'(i); #1;
      total++; if (imm_value !== exp_mem[i]) begin bad++; $display("FAIL sdl_data idx=%0d got=%02h exp=%02h", i, imm_value, exp_mem[i]); end
    end
    $display("test_start_during_load done err=%0b", load_err);
  endtask

  task automatic test_idle_valid();
    rst_n = 1'b0; #2; rst_n = 1'b1;
    step();
    push(8'hAA);
    total++; if (load_err !== 1'b1) begin bad++; $display("FAIL idle_err got=%0b exp=1", load_err); end
    for (int i = 0; i < 32; i++) begin
      index = 5'(i); #1;
      total++; if (imm_value !== 8'h00) begin bad++; $display("FAIL idle_data idx=%0d got=%02h exp=00", i, imm_value); end
    end
    pulse_start();
    total++; if (load_err !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL idle_restart err=%0b busy=%0b exp=0/1", load_err, busy); end
    $display("test_idle_valid done");
  endtask

  task automatic test_reload();
    for (int i = 0; i < 32; i++) push(8'(i));
    total++; if (imm_valid !== 1'b1) begin bad++; $display("FAIL reload_pre got=%0b exp=1", imm_valid); end
    pulse_start();
    for (int i = 0; i < 32; i++) begin
      total++; if (imm_valid !== 1'b0) begin bad++; $display("FAIL reload_valid i=%0d got=%0b exp=0", i, imm_valid); end
      push(8'(8'hFF - i));
    end
    total++; if (imm_valid !== 1'b1) begin bad++; $display("FAIL reload_done got=%0b exp=1", imm_valid); end
    index = 5'd0; #1;
    total++; if (imm_value !== 8'hFF) begin bad++; $display("FAIL reload_idx0 got=%02h exp=ff", imm_value); end
    index = 5'd31; #1;
    total++; if (imm_value !== 8'hE0) begin bad++; $display("FAIL reload_idx31 got=%02h exp=e0", imm_value); end
    $display("test_reload done");
  endtask

  task automatic test_reset_mid_load();
    pulse_start();
    for (int i = 0; i < 20; i++) push(8'(8'h80 + i));
    total++; if (load_count !== 6'd20) begin bad++; $display("FAIL rml_pre count=%0d exp=20", load_count); end
    #2; rst_n = 1'b0; #1;
    total++; if (busy !== 1'b0 || load_count !== 6'd0 || load_ready !== 1'b0) begin bad++; $display("FAIL rml_async busy=%0b count=%0d ready=%0b exp=0/0/0", busy, load_count, load_ready); end
    index = 5'd3; #1;
    total++; if (imm_value !== 8'h00) begin bad++; $display("FAIL rml_entry got=%02h exp=00", imm_value); end
    step();
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      total++; if (imm_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL rml_idle c=%0d valid=%0b busy=%0b exp=0/0", c, imm_valid, busy); end
    end
    pulse_start();
    for (int i = 0; i < 32; i++) begin
      if (i == 31) begin
        total++; if (imm_valid !== 1'b0) begin bad++; $display("FAIL rml_early got=%0b exp=0", imm_valid); end
      end
      push(8'(8'h10 + i));
    end
    index = 5'd19; #1;
    total++; if (imm_valid !== 1'b1 || imm_value !== 8'h23) begin bad++; $display("FAIL rml_final valid=%0b val=%02h exp=1/23", imm_valid, imm_value); end
    $display("test_reset_mid_load done");
  endtask

  initial begin
    test_reset();
    test_full_load();
    test_stall();
    test_start_during_load();
    test_idle_valid();
    test_reload();
    test_reset_mid_load();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/imm_lut_loader.md
IMM_LUT_LOADER -- requirements
Module: imm_lut_loader

Interface
REQ-001 Parameter DATA_PATH_WIDTH, default 8, width of each immediate entry and of all data ports.
REQ-002 Parameter LUT_SIZE, default 32, number of entries; fixed at 32 because the index is 5 bits.
REQ-003 clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert and active-low.
REQ-005 load_start  input  1  one-cycle pulse that begins a full-table load.
REQ-006 load_valid  input  1  producer has an entry on load_data.
REQ-007 load_data  input  DATA_PATH_WIDTH  next immediate value, in index order 0..31.
REQ-008 load_ready  output  1  block accepts load_data this cycle.
REQ-009 index  input  5  read index from LOAD_IMM decode.
REQ-010 imm_value  output  DATA_PATH_WIDTH  entry at index.
REQ-011 imm_valid  output  1  table fully loaded; imm_value is trustworthy.
REQ-012 busy  output  1  load in progress; the core stalls LOAD_IMM while high.
REQ-013 load_count  output  6  entries accepted in the current or last load, 0..32.
REQ-014 load_err  output  1  sticky protocol-violation flag.

Function
REQ-015 The FSM SHALL have the states IDLE, LOAD and DONE.
REQ-016 IDLE: load_ready=0, busy=0, imm_valid=0; load_start moves the FSM to LOAD with the pointer and load_count set to 0.
REQ-017 LOAD: load_ready=1, busy=1; a handshake (load_valid&load_ready) writes load_data to entry[ptr] at that clock edge and increments ptr and load_count.
REQ-018 The handshake at ptr==31 SHALL write entry 31, set load_count to 32 and move the FSM to DONE in the same edge; ptr SHALL NOT wrap.
REQ-019 DONE: load_ready=0, busy=0, imm_valid=1; load_start moves the FSM back to LOAD (reload) and drops imm_valid the next cycle.
REQ-020 load_start while in LOAD SHALL be ignored and SHALL set load_err; the load continues undisturbed.
REQ-021 load_valid=1 while the FSM is not in LOAD SHALL NOT write any entry and SHALL set load_err.
REQ-022 load_err SHALL clear only on reset or on an accepted load_start (IDLE/DONE to LOAD); a violation in the same cycle as that start SHALL NOT set load_err.
REQ-023 load_valid held low in LOAD SHALL stall indefinitely with no timeout and no state change.
REQ-024 imm_value SHALL be combinational from index and the entry array (zero-latency read).
REQ-025 During LOAD, imm_value SHALL still reflect current array contents, including partially written entries; consumers gate use with imm_valid.
REQ-026 A write and a read of the same index in one cycle SHALL return the old value that cycle and the new value from the next cycle.
REQ-027 Index and pointer arithmetic SHALL be 5-bit; load_count SHALL be 6-bit so that 32 is representable.

Reset
REQ-028 rst_n low SHALL force IDLE, ptr=0, load_count=0, load_err=0 and all 32 entries=0, asynchronously.
REQ-029 Reset values of the outputs SHALL be: load_ready=0, busy=0, imm_valid=0, imm_value=0.
REQ-030 Reset asserted mid-LOAD SHALL discard the partial load; after release, a new load_start is required.

Structure
REQ-031 A shared package SHALL hold the FSM state enum, LUT_SIZE and the 5-bit index width constant.
REQ-032 The entry storage SHALL be one sub-module, imm_lut_ram, with one synchronous write port, one combinational read port and async reset to zero; the FSM and counters stay in the top module.

Verification
REQ-033 Reset, then load_start, then 32 back-to-back valid entries 0x00..0x1F -> imm_valid rises the cycle after the 32nd handshake, load_count=32, index=5 gives 0x05, and index=31 gives 0x1F.
REQ-034 Load with load_valid dropped for 10 cycles after entry 7 -> busy stays 1, load_count stays 8, and the load completes correctly with 32 entries.
REQ-035 load_start pulsed at entry 12 of a load -> load_err=1, and the load still completes with all 32 values correct.
REQ-036 load_valid=1 with 0xAA while in IDLE -> no entry changes (all reads 0x00) and load_err=1; the next load_start clears load_err.
REQ-037 Reload from DONE with values 0xFF..0xE0 -> imm_valid=0 throughout LOAD and index=0 gives 0xFF after DONE.
REQ-038 rst_n low after 20 entries -> state IDLE, entries 0, load_count=0, and imm_valid stays 0 until a full new load.
